// File: rtl/hazard_scoreboard_if.sv
// ID-stage <-> hazard_scoreboard bundle: ID decode fields, flush, WB retire, stall outputs.
// SCOREBOARD_PERF_EN adds the two stall-cause performance counters.
interface hazard_scoreboard_if;
  logic        id_valid;
  logic [4:0]  id_rs1_label;
  logic [4:0]  id_rs2_label;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic [4:0]  id_rd_label;
  logic        id_reg_wb_en;
  logic        id_is_load;
  logic        id_is_muldiv;
  logic        ex_flush;
  logic        wb_valid;
  logic [4:0]  wb_rd_label;
  logic        stall_id;
  logic        bubble_ex;
  logic        muldiv_busy;
  logic        muldiv_timeout;
  logic [31:0] pending;
`ifdef SCOREBOARD_PERF_EN
  logic [31:0] load_use_stalls;
  logic [31:0] muldiv_stalls;
`endif

  modport master (
    output id_valid, id_rs1_label, id_rs2_label, id_uses_rs1, id_uses_rs2,
    output id_rd_label, id_reg_wb_en, id_is_load, id_is_muldiv,
    output ex_flush, wb_valid, wb_rd_label,
`ifdef SCOREBOARD_PERF_EN
    input  load_use_stalls, muldiv_stalls,
`endif
    input  stall_id, bubble_ex, muldiv_busy, muldiv_timeout, pending
  );

  modport slave (
    input  id_valid, id_rs1_label, id_rs2_label, id_uses_rs1, id_uses_rs2,
    input  id_rd_label, id_reg_wb_en, id_is_load, id_is_muldiv,
    input  ex_flush, wb_valid, wb_rd_label,
`ifdef SCOREBOARD_PERF_EN
    output load_use_stalls, muldiv_stalls,
`endif
    output stall_id, bubble_ex, muldiv_busy, muldiv_timeout, pending
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writers and stalls ID on load-use, mul/div RAW and mul/div busy.
// Optional SCOREBOARD_PERF_EN adds load-use and mul/div stall-cycle counters.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned MULDIV_MAX = 34
) (
  input  logic               clk_i,
  input  logic               rst_i,
  hazard_scoreboard_if.slave sb
);

  typedef enum logic [1:0] {
    KindAlu    = 2'd0,
    KindLoad   = 2'd1,
    KindMuldiv = 2'd2
  } kind_e;

  localparam int unsigned    CntW    = 6;
  localparam logic [CntW-1:0] CntLast = CntW'(MULDIV_MAX - 1);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [1:0]          age_q  [NUM_REGS];
  logic [1:0]          age_d  [NUM_REGS];
  kind_e               kind_q [NUM_REGS];
  kind_e               kind_d [NUM_REGS];
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                timeout_q, timeout_d;

  logic busy;
  logic rs1_pend, rs2_pend;
  logic rs1_load, rs2_load;
  logic rs1_md, rs2_md;
  logic load_hit, md_hit;
  logic stall;
  logic issue;
  logic timeout_fire;

  always_comb begin
    busy = 1'b0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (pend_q[r] && kind_q[r] == KindMuldiv) busy = 1'b1;
    end
  end

  // Load at age 0 is still in EX: its data reaches MEM/WB forwarding only next cycle.
  always_comb begin
    rs1_pend = sb.id_uses_rs1 && (sb.id_rs1_label != '0) && pend_q[sb.id_rs1_label];
    rs2_pend = sb.id_uses_rs2 && (sb.id_rs2_label != '0) && pend_q[sb.id_rs2_label];
    rs1_load = rs1_pend && kind_q[sb.id_rs1_label] == KindLoad &&
               age_q[sb.id_rs1_label] == 2'd0;
    rs2_load = rs2_pend && kind_q[sb.id_rs2_label] == KindLoad &&
               age_q[sb.id_rs2_label] == 2'd0;
    rs1_md   = rs1_pend && kind_q[sb.id_rs1_label] == KindMuldiv;
    rs2_md   = rs2_pend && kind_q[sb.id_rs2_label] == KindMuldiv;
    load_hit = rs1_load || rs2_load;
    md_hit   = rs1_md || rs2_md || (sb.id_is_muldiv && busy);
    stall    = !rst_i && sb.id_valid && !sb.ex_flush && (load_hit || md_hit);
    issue    = sb.id_valid && !stall && !sb.ex_flush;
  end

  assign timeout_fire = busy && (cnt_q == CntLast);

  always_comb begin
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    for (int r = 0; r < NUM_REGS; r++) begin
      age_d[r]  = age_q[r];
      kind_d[r] = kind_q[r];
    end

    for (int r = 1; r < NUM_REGS; r++) begin
      // Mul/div results leave through the long-latency unit, so their age never advances.
      if (pend_q[r] && kind_q[r] != KindMuldiv && age_q[r] != 2'd2) begin
        age_d[r] = age_q[r] + 2'd1;
      end
      if (sb.ex_flush && pend_q[r] && age_q[r] == 2'd0) pend_d[r] = 1'b0;
      if (timeout_fire && pend_q[r] && kind_q[r] == KindMuldiv) pend_d[r] = 1'b0;
    end

    if (sb.wb_valid && sb.wb_rd_label != '0) pend_d[sb.wb_rd_label] = 1'b0;

    // Issue is applied last so it wins over a same-cycle retire of the same rd.
    if (issue && sb.id_reg_wb_en && sb.id_rd_label != '0) begin
      pend_d[sb.id_rd_label] = 1'b1;
      age_d[sb.id_rd_label]  = 2'd0;
      if (sb.id_is_muldiv)    kind_d[sb.id_rd_label] = KindMuldiv;
      else if (sb.id_is_load) kind_d[sb.id_rd_label] = KindLoad;
      else                    kind_d[sb.id_rd_label] = KindAlu;
    end
    pend_d[0] = 1'b0;

    if (timeout_fire) begin
      timeout_d = 1'b1;
      cnt_d     = '0;
    end else if (busy) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        age_q[r]  <= 2'd0;
        kind_q[r] <= KindAlu;
      end
    end else begin
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      for (int r = 0; r < NUM_REGS; r++) begin
        age_q[r]  <= age_d[r];
        kind_q[r] <= kind_d[r];
      end
    end
  end

  // Outputs are forced low while reset is asserted, before the state has been cleared.
  assign sb.stall_id       = stall;
  assign sb.bubble_ex      = stall;
  assign sb.muldiv_busy    = !rst_i && busy;
  assign sb.muldiv_timeout = !rst_i && timeout_q;
  assign sb.pending        = rst_i ? 32'd0 : 32'(pend_q);

`ifdef SCOREBOARD_PERF_EN
  logic [31:0] lu_cnt_q, md_cnt_q;

  // A cycle with both causes is attributed to load-use only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lu_cnt_q <= '0;
      md_cnt_q <= '0;
    end else if (stall) begin
      if (load_hit) lu_cnt_q <= lu_cnt_q + 32'd1;
      else          md_cnt_q <= md_cnt_q + 32'd1;
    end
  end

  assign sb.load_use_stalls = rst_i ? 32'd0 : lu_cnt_q;
  assign sb.muldiv_stalls   = rst_i ? 32'd0 : md_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scenarios plus a randomized run against a timestamp-based scoreboard model.
module tb_hazard_scoreboard;
  localparam int KAlu = 0;
  localparam int KLoad = 1;
  localparam int KMd = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   tests_failed = 0;

  // Reference model: per-register pending flag, kind and issue cycle number.
  bit m_pend [32];
  int m_kind [32];
  int m_iss  [32];
  bit m_to;
  int m_cyc;
  int m_lu;
  int m_md;

  hazard_scoreboard_if sb();

  hazard_scoreboard #(.NUM_REGS(32), .MULDIV_MAX(34)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .sb    (sb)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    sb.id_valid = 0; sb.id_rs1_label = 0; sb.id_rs2_label = 0; sb.id_uses_rs1 = 0;
    sb.id_uses_rs2 = 0; sb.id_rd_label = 0; sb.id_reg_wb_en = 0; sb.id_is_load = 0;
    sb.id_is_muldiv = 0; sb.ex_flush = 0; sb.wb_valid = 0; sb.wb_rd_label = 0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic wen,
                        input logic ld, input logic md);
    sb.id_valid = 1; sb.id_rs1_label = rs1; sb.id_rs2_label = rs2; sb.id_uses_rs1 = u1;
    sb.id_uses_rs2 = u2; sb.id_rd_label = rd; sb.id_reg_wb_en = wen; sb.id_is_load = ld;
    sb.id_is_muldiv = md;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  function automatic bit m_load_hit(input logic [4:0] rs, input logic u);
    return u && rs != 0 && m_pend[rs] && m_kind[rs] == KLoad && (m_cyc - m_iss[rs] - 1) == 0;
  endfunction

  function automatic bit m_md_hit(input logic [4:0] rs, input logic u);
    return u && rs != 0 && m_pend[rs] && m_kind[rs] == KMd;
  endfunction

  task automatic test_reset();
    do_reset();
    set_id(0, 0, 0, 0, 5, 1, 0, 1);  // mul x5
    step();
    set_id(5, 0, 1, 0, 6, 1, 0, 0);  // consumer of x5
    rst = 1;
    settle();
    tests_run++; if (sb.stall_id !== 1'b0) begin tests_failed++; $display("FAIL rst_stall_during: got %b want 0", sb.stall_id); end
    tests_run++; if (sb.muldiv_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy_during: got %b want 0", sb.muldiv_busy); end
    tests_run++; if (sb.pending !== 32'd0) begin tests_failed++; $display("FAIL rst_pending_during: got %h want 0", sb.pending); end
    step();
    rst = 0;
    settle();
    tests_run++; if (sb.stall_id !== 1'b0) begin tests_failed++; $display("FAIL rst_stall_after: got %b want 0", sb.stall_id); end
    tests_run++; if (sb.muldiv_busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy_after: got %b want 0", sb.muldiv_busy); end
    tests_run++; if (sb.muldiv_timeout !== 1'b0) begin tests_failed++; $display("FAIL rst_timeout_after: got %b want 0", sb.muldiv_timeout); end
    idle_inputs();
    sb.wb_valid = 1; sb.wb_rd_label = 5;  // late WB of the dropped mul
    step();
    idle_inputs();
    settle();
    tests_run++; if (sb.pending !== 32'd0) begin tests_failed++; $display("FAIL rst_late_wb: got %h want 0", sb.pending); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(0, 0, 0, 0, 5, 1, 1, 0);  // load x5
    settle();
    tests_run++; if (sb.stall_id !== 1'b0) begin tests_failed++; $display("FAIL t1_load_issue: got %b want 0", sb.stall_id); end
    step();
    set_id(5, 1, 1, 1, 6, 1, 0, 0);  // add x6,x5,x1
    settle();
    tests_run++; if (sb.stall_id !== 1'b1) begin tests_failed++; $display("FAIL t1_stall: got %b want 1", sb.stall_id); end
    tests_run++; if (sb.bubble_ex !== 1'b1) begin tests_failed++; $display("FAIL t1_bubble: got %b want 1", sb.bubble_ex); end
    step();
    settle();
    tests_run++; if (sb.stall_id !== 1'b0) begin tests_failed++; $display("FAIL t1_release: got %b want 0", sb.stall_id); end
    step();
    idle_inputs();
    settle();
    tests_run++; if (sb.pending[6] !== 1'b1) begin tests_failed++; $display("FAIL t1_add_issued: got %b want 1", sb.pending[6]); end
`ifdef SCOREBOARD_PERF_EN
    tests_run++; if (sb.load_use_stalls !== 32'd1) begin tests_failed++; $display("FAIL t1_perf: got %0d want 1", sb.load_use_stalls); end
`endif
  endtask

  task automatic test_alu_forward();
    do_reset();
    set_id(0, 0, 0, 0, 5, 1, 0, 0);  // add x5
    step();
    set_id(5, 5, 1, 1, 7, 1, 0, 0);  // sub x7,x5,x5
    settle();
    tests_run++; if (sb.stall_id !== 1'b0) begin tests_failed++; $display("FAIL t2_no_stall: got %b want 0", sb.stall_id); end
    tests_run++; if (sb.pending[5] !== 1'b1) begin tests_failed++; $display("FAIL t2_pend5: got %b want 1", sb.pending[5]); end
    step();
    idle_inputs();
    sb.wb_valid = 1; sb.wb_rd_label = 5;
    settle();
    tests_run++; if (sb.pending[5] !== 1'b1) begin tests_failed++; $display("FAIL t2_pend5_wb_cycle: got %b want 1", sb.pending[5]); end
    step();
    idle_inputs();
    settle();
    tests_run++; if (sb.pending[5] !== 1'b0) begin tests_failed++; $display("FAIL t2_pend5_retired: got %b want 0", sb.pending[5]); end
  endtask

  task automatic test_muldiv();
    do_reset();
    set_id(0, 0, 0, 0, 8, 1, 0, 1);  // mul x8
    step();
    set_id(1, 2, 1, 1, 9, 1, 0, 1);  // div x9,x1,x2
    for (int i = 0; i < 3; i++) begin
      settle();
      tests_run++; if (sb.stall_id !== 1'b1) begin tests_failed++; $display("FAIL t3_struct_stall%0d: got %b want 1", i, sb.stall_id); end
      step();
    end
    sb.wb_valid = 1; sb.wb_rd_label = 8;
    settle();
    tests_run++; if (sb.stall_id !== 1'b1) begin tests_failed++; $display("FAIL t3_stall_wb_cycle: got %b want 1", sb.stall_id); end
    tests_run++; if (sb.muldiv_busy !== 1'b1) begin tests_failed++; $display("FAIL t3_busy_wb_cycle: got %b want 1", sb.muldiv_busy); end
    step();
    sb.wb_valid = 0;
    settle();
    tests_run++; if (sb.muldiv_busy !== 1'b0) begin tests_failed++; $display("FAIL t3_busy_drop: got %b want 0", sb.muldiv_busy); end
    tests_run++; if (sb.stall_id !== 1'b0) begin tests_failed++; $display("FAIL t3_div_issue: got %b want 0", sb.stall_id); end
    step();
    set_id(8, 0, 1, 1, 10, 1, 0, 0);  // add x10,x8,x0
    settle();
    tests_run++; if (sb.stall_id !== 1'b0) begin tests_failed++; $display("FAIL t3_add_no_stall: got %b want 0", sb.stall_id); end
    tests_run++; if (sb.pending[9] !== 1'b1) begin tests_failed++; $display("FAIL t3_div_pending: got %b want 1", sb.pending[9]); end
    step();
    idle_inputs();
    settle();
    tests_run++; if (sb.pending[10] !== 1'b1) begin tests_failed++; $display("FAIL t3_add_issued: got %b want 1", sb.pending[10]); end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(0, 0, 0, 0, 3, 1, 1, 0);  // load x3
    step();
    set_id(3, 0, 1, 0, 12, 1, 0, 0);
    sb.ex_flush = 1;
    settle();
    tests_run++; if (sb.stall_id !== 1'b0) begin tests_failed++; $display("FAIL t4_no_stall: got %b want 0", sb.stall_id); end
    step();
    idle_inputs();
    settle();
    tests_run++; if (sb.pending[3] !== 1'b0) begin tests_failed++; $display("FAIL t4_pend3: got %b want 0", sb.pending[3]); end
    tests_run++; if (sb.pending[12] !== 1'b0) begin tests_failed++; $display("FAIL t4_no_issue: got %b want 0", sb.pending[12]); end
  endtask

  task automatic test_wb_issue_same_cycle();
    do_reset();
    set_id(0, 0, 0, 0, 4, 1, 0, 0);  // add x4
    step();
    idle_inputs();
    step();
    set_id(0, 0, 0, 0, 4, 1, 1, 0);  // load x4 alongside WB of x4
    sb.wb_valid = 1; sb.wb_rd_label = 4;
    step();
    idle_inputs();
    set_id(4, 0, 1, 0, 11, 1, 0, 0);
    settle();
    tests_run++; if (sb.pending[4] !== 1'b1) begin tests_failed++; $display("FAIL t5_pend4: got %b want 1", sb.pending[4]); end
    tests_run++; if (sb.stall_id !== 1'b1) begin tests_failed++; $display("FAIL t5_stall: got %b want 1", sb.stall_id); end
    step();
    settle();
    tests_run++; if (sb.stall_id !== 1'b0) begin tests_failed++; $display("FAIL t5_release: got %b want 0", sb.stall_id); end
    step();
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    set_id(0, 0, 0, 0, 2, 1, 0, 1);  // mul x2
    step();
    idle_inputs();
    for (int i = 0; i < 33; i++) step();
    settle();
    tests_run++; if (sb.muldiv_timeout !== 1'b0) begin tests_failed++; $display("FAIL t6_early: got %b want 0", sb.muldiv_timeout); end
    tests_run++; if (sb.pending[2] !== 1'b1) begin tests_failed++; $display("FAIL t6_pend_early: got %b want 1", sb.pending[2]); end
    step();
    settle();
    tests_run++; if (sb.muldiv_timeout !== 1'b1) begin tests_failed++; $display("FAIL t6_timeout: got %b want 1", sb.muldiv_timeout); end
    tests_run++; if (sb.pending[2] !== 1'b0) begin tests_failed++; $display("FAIL t6_pend_clear: got %b want 0", sb.pending[2]); end
    tests_run++; if (sb.muldiv_busy !== 1'b0) begin tests_failed++; $display("FAIL t6_busy_clear: got %b want 0", sb.muldiv_busy); end
    step();
    settle();
    tests_run++; if (sb.muldiv_timeout !== 1'b1) begin tests_failed++; $display("FAIL t6_sticky: got %b want 1", sb.muldiv_timeout); end
    rst = 1;
    step();
    rst = 0;
    settle();
    tests_run++; if (sb.muldiv_timeout !== 1'b0) begin tests_failed++; $display("FAIL t6_rst: got %b want 0", sb.muldiv_timeout); end
  endtask

  task automatic test_random();
    bit          busy, ld_hit, md_hit, exp_stall, issue, fire;
    logic [31:0] exp_pend;
    int          fire_r;
    do_reset();
    for (int r = 0; r < 32; r++) begin m_pend[r] = 0; m_kind[r] = KAlu; m_iss[r] = 0; end
    m_to = 0; m_cyc = 0; m_lu = 0; m_md = 0;
    for (int n = 0; n < 3000; n++) begin
      sb.id_valid     = ($urandom_range(9) < 7);
      sb.id_rs1_label = 5'($urandom_range(7));
      sb.id_rs2_label = 5'($urandom_range(7));
      sb.id_uses_rs1  = ($urandom_range(3) != 0);
      sb.id_uses_rs2  = ($urandom_range(1) != 0);
      sb.id_rd_label  = 5'($urandom_range(7));
      sb.id_reg_wb_en = ($urandom_range(4) != 0);
      sb.id_is_load   = ($urandom_range(3) == 0);
      sb.id_is_muldiv = ($urandom_range(7) == 0);
      sb.ex_flush     = ($urandom_range(24) == 0);
      sb.wb_valid     = ($urandom_range(2) == 0);
      sb.wb_rd_label  = 5'($urandom_range(7));

      busy = 0;
      exp_pend = 32'd0;
      for (int r = 1; r < 32; r++) begin
        if (m_pend[r] && m_kind[r] == KMd) busy = 1;
        exp_pend[r] = m_pend[r];
      end
      ld_hit = m_load_hit(sb.id_rs1_label, sb.id_uses_rs1) ||
               m_load_hit(sb.id_rs2_label, sb.id_uses_rs2);
      md_hit = m_md_hit(sb.id_rs1_label, sb.id_uses_rs1) ||
               m_md_hit(sb.id_rs2_label, sb.id_uses_rs2) || (sb.id_is_muldiv && busy);
      exp_stall = sb.id_valid && !sb.ex_flush && (ld_hit || md_hit);

      settle();
      tests_run++; if (sb.stall_id !== exp_stall) begin tests_failed++; $display("FAIL rnd_stall@%0d: got %b want %b", n, sb.stall_id, exp_stall); end
      tests_run++; if (sb.bubble_ex !== exp_stall) begin tests_failed++; $display("FAIL rnd_bubble@%0d: got %b want %b", n, sb.bubble_ex, exp_stall); end
      tests_run++; if (sb.muldiv_busy !== busy) begin tests_failed++; $display("FAIL rnd_busy@%0d: got %b want %b", n, sb.muldiv_busy, busy); end
      tests_run++; if (sb.muldiv_timeout !== m_to) begin tests_failed++; $display("FAIL rnd_timeout@%0d: got %b want %b", n, sb.muldiv_timeout, m_to); end
      tests_run++; if (sb.pending !== exp_pend) begin tests_failed++; $display("FAIL rnd_pending@%0d: got %h want %h", n, sb.pending, exp_pend); end

      if (exp_stall) begin
        if (ld_hit) m_lu++;
        else        m_md++;
      end
      issue = sb.id_valid && !exp_stall && !sb.ex_flush;
      fire = 0;
      fire_r = 0;
      for (int r = 1; r < 32; r++) begin
        if (m_pend[r] && m_kind[r] == KMd && (m_cyc - m_iss[r]) == 34) begin
          fire = 1; fire_r = r;
        end
      end
      if (sb.ex_flush) begin
        for (int r = 1; r < 32; r++) begin
          if (m_pend[r] && (m_kind[r] == KMd || (m_cyc - m_iss[r] - 1) == 0)) m_pend[r] = 0;
        end
      end
      if (fire) begin m_to = 1; m_pend[fire_r] = 0; end
      if (sb.wb_valid && sb.wb_rd_label != 0) m_pend[sb.wb_rd_label] = 0;
      if (issue && sb.id_reg_wb_en && sb.id_rd_label != 0) begin
        m_pend[sb.id_rd_label] = 1;
        m_kind[sb.id_rd_label] = sb.id_is_muldiv ? KMd : (sb.id_is_load ? KLoad : KAlu);
        m_iss[sb.id_rd_label]  = m_cyc;
      end
      m_cyc++;
      step();
    end
    idle_inputs();
`ifdef SCOREBOARD_PERF_EN
    settle();
    tests_run++; if (sb.load_use_stalls !== 32'(m_lu)) begin tests_failed++; $display("FAIL rnd_perf_lu: got %0d want %0d", sb.load_use_stalls, m_lu); end
    tests_run++; if (sb.muldiv_stalls !== 32'(m_md)) begin tests_failed++; $display("FAIL rnd_perf_md: got %0d want %0d", sb.muldiv_stalls, m_md); end
`endif
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    test_reset();
    test_load_use();
    test_alu_forward();
    test_muldiv();
    test_flush();
    test_wb_issue_same_cycle();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
